// File: rtl/mrd_gather_rdx.sv
// Serial-to-parallel gather for a radix-2..5 butterfly.
// Collects R complex samples starting at a sop beat, emits them as one
// parallel group together with the group's block exponent and its headroom
// (minimum sign-bit redundancy, saturated to 3). Broken or illegal groups
// raise a one-cycle err pulse and are discarded.
//
// state   | meaning
// ST_IDLE | no group open, waiting for a sop beat
// ST_FILL | group open, r_cnt samples (1..R-1) already accepted
module mrd_gather_rdx (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [2:0]         radix,
  input  logic               in_val,
  input  logic               sop,
  input  logic signed [17:0] din_real,
  input  logic signed [17:0] din_imag,
  input  logic [3:0]         exp_in,
  output logic               out_val,
  output logic signed [17:0] dout_real [0:4],
  output logic signed [17:0] dout_imag [0:4],
  output logic [1:0]         margin_out,
  output logic [3:0]         exp_out,
  output logic               err
);

  typedef enum logic {ST_IDLE, ST_FILL} state_t;

  state_t             r_state;
  logic [2:0]         r_cnt;
  logic [2:0]         r_rad;
  logic [3:0]         r_exp;
  logic [1:0]         r_marg;
  logic signed [17:0] r_buf_re [0:4];
  logic signed [17:0] r_buf_im [0:4];

  logic       w_legal;
  logic       w_sop_beat;
  logic       w_data_beat;
  logic       w_last;
  logic [1:0] w_red_re;
  logic [1:0] w_red_im;
  logic [1:0] w_red_smp;
  logic [1:0] w_marg_next;

  // Redundant sign bits below bit 17; only values up to 3 matter downstream.
  function automatic logic [1:0] red_sat(input logic signed [17:0] x);
    logic [1:0] r;
    if (x[16] != x[17])      r = 2'd0;
    else if (x[15] != x[17]) r = 2'd1;
    else if (x[14] != x[17]) r = 2'd2;
    else                     r = 2'd3;
    return r;
  endfunction

  // Beat qualification and running-minimum headroom of the incoming sample.
  always_comb begin
    w_legal     = (radix >= 3'd2) && (radix <= 3'd5);
    w_sop_beat  = in_val & sop;
    w_data_beat = in_val & ~sop & (r_state == ST_FILL);
    w_last      = w_data_beat && (r_cnt == (r_rad - 3'd1));
    w_red_re    = red_sat(din_real);
    w_red_im    = red_sat(din_imag);
    w_red_smp   = (w_red_re < w_red_im) ? w_red_re : w_red_im;
    w_marg_next = (r_marg < w_red_smp) ? r_marg : w_red_smp;
  end

  // Gather FSM with registered group outputs and error pulse.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_cnt      <= 3'd0;
      r_rad      <= 3'd0;
      r_exp      <= 4'd0;
      r_marg     <= 2'd0;
      out_val    <= 1'b0;
      err        <= 1'b0;
      margin_out <= 2'd0;
      exp_out    <= 4'd0;
      for (int k = 0; k < 5; k++) begin
        r_buf_re[k]  <= '0;
        r_buf_im[k]  <= '0;
        dout_real[k] <= '0;
        dout_imag[k] <= '0;
      end
    end else begin
      out_val <= 1'b0;
      err     <= 1'b0;
      if (w_sop_beat) begin
        // A sop always closes whatever was open; an open group is lost.
        if ((r_state == ST_FILL) || !w_legal) err <= 1'b1;
        if (w_legal) begin
          r_state <= ST_FILL;
          r_cnt   <= 3'd1;
          r_rad   <= radix;
          r_exp   <= exp_in;
          r_marg  <= w_red_smp;
          // Clearing the buffer here keeps unused lanes R..4 at zero.
          for (int k = 0; k < 5; k++) begin
            r_buf_re[k] <= (k == 0) ? din_real : '0;
            r_buf_im[k] <= (k == 0) ? din_imag : '0;
          end
        end else begin
          r_state <= ST_IDLE;
          r_cnt   <= 3'd0;
        end
      end else if (w_data_beat) begin
        for (int k = 0; k < 5; k++) begin
          if (3'(k) == r_cnt) begin
            r_buf_re[k] <= din_real;
            r_buf_im[k] <= din_imag;
          end
        end
        if (w_last) begin
          // Bypass the final sample straight into the output register.
          out_val    <= 1'b1;
          margin_out <= w_marg_next;
          exp_out    <= r_exp;
          for (int k = 0; k < 5; k++) begin
            dout_real[k] <= (3'(k) == r_cnt) ? din_real : r_buf_re[k];
            dout_imag[k] <= (3'(k) == r_cnt) ? din_imag : r_buf_im[k];
          end
          r_state <= ST_IDLE;
          r_cnt   <= 3'd0;
        end else begin
          r_cnt  <= r_cnt + 3'd1;
          r_marg <= w_marg_next;
        end
      end
    end
  end

endmodule

// File: doc/mrd_gather_rdx.md
MRD_GATHER_RDX -- requirements
Module: mrd_gather_rdx

Interface
REQ-001 Port clk, input, 1: single clock; all state changes on its rising edge.
REQ-002 Port rst_n, input, 1: reset, synchronous and active-low.
REQ-003 Port radix, input, 3: butterfly radix, legal values 2, 3, 4, 5; sampled only on a sop beat.
REQ-004 Port in_val, input, 1: serial sample valid, one complex sample per asserted cycle.
REQ-005 Port sop, input, 1: first sample of a group; qualified by in_val.
REQ-006 Port din_real / din_imag, input, 18 each: signed serial sample.
REQ-007 Port exp_in, input, 4: unsigned block exponent; sampled on the sop beat.
REQ-008 Port out_val, output, 1: one-cycle pulse; vector outputs valid.
REQ-009 Port dout_real[0:4] / dout_imag[0:4], output, 18 each: signed parallel group, lane k = k-th sample of the group.
REQ-010 Port margin_out, output, 2: unsigned headroom of the group, for the butterfly's margin_in.
REQ-011 Port exp_out, output, 4: exp_in latched for the group.
REQ-012 Port err, output, 1: one-cycle pulse on a dropped or illegal group.

Function
REQ-013 States: IDLE (cnt=0, no group open) and FILL (cnt = samples accepted, 1..R-1, R = latched radix).
REQ-014 IDLE with in_val & sop & legal radix -> store sample in lane 0, latch R and exp_in, go to FILL with cnt=1.
REQ-015 IDLE with in_val & ~sop -> sample discarded, no err, stay IDLE.
REQ-016 IDLE with in_val & sop & illegal radix (0, 1, 6, 7) -> sample discarded, err pulses the next cycle, stay IDLE.
REQ-017 FILL with in_val & ~sop -> store in lane cnt, cnt+1; when cnt reaches R, the group is complete and the state returns to IDLE.
REQ-018 FILL with in_val & sop -> partial group discarded, err pulses the next cycle, and the sop beat is processed as in REQ-014 or REQ-016.
REQ-019 FILL with in_val low -> hold; no timeout.
REQ-020 Latency: out_val is high exactly one cycle after the cycle that accepts the R-th sample.
REQ-021 Back-to-back: a new group's sop may arrive the cycle after the last sample of the previous group; the output register holds group n while group n+1 fills, with no bubble required.
REQ-022 Lanes R..4 are driven as 0 when out_val is high.
REQ-023 Outputs dout_*, margin_out and exp_out hold their value until the next out_val.
REQ-024 Per-component redundancy is the count of leading bits below bit 17 that equal bit 17.
  - Examples: 18'sh1FFFF -> 0; 18'sh08000 -> 1; 18'sh00000 -> 17.
REQ-025 margin_out is the minimum redundancy over all 2R components of the group, saturated to 3.
REQ-026 The margin is computed incrementally as samples arrive; no extra latency beyond REQ-020.
REQ-027 A group dropped per REQ-018 never produces out_val, and its samples do not affect any later margin.

Reset
REQ-028 rst_n low at a clock edge -> state IDLE, cnt 0, out_val 0, err 0, dout_* 0, margin_out 0, exp_out 0.
REQ-029 Reset in mid-FILL aborts the group silently: no out_val, no err.
REQ-030 Samples with in_val high during reset are ignored.

Verification
REQ-031 radix=5, exp_in=4, five samples real=imag=k*16 (k=0..4) on consecutive cycles with sop on the first.
  - Expected: out_val one cycle after the 5th sample; dout lanes 0..4 = 0,16,32,48,64; margin_out=3; exp_out=4.
REQ-032 radix=3, samples 18'sh1FFFF, 1, 2 (imag=0).
  - Expected: lanes 0..2 hold those values; lanes 3,4 = 0; margin_out=0.
REQ-033 radix=2, samples 18'sh08000 and 18'sh3FFFF.
  - Expected: margin_out=1.
REQ-034 radix=4, sop at sample 0, a second sop at sample 2.
  - Expected: err pulses once; out_val comes only after 4 samples counted from the second sop.
REQ-035 radix=4, 40 consecutive samples with sop every 4th beat.
  - Expected: 10 out_val pulses spaced exactly 4 cycles apart, in correct order, with no err.
REQ-036 Reset asserted after 2 of 5 samples, then a fresh radix=2 group.
  - Expected: no output for the aborted group; the radix=2 group is emitted correctly; sop with radix=6 yields err and no out_val.
